// File: rtl/i2c_target_reg.sv
// i2c_target_reg: 7-bit-address I2C target. Write bytes land in rx_data; tx_data is
// shifted out on reads. SCL is only observed, and SDA is only ever pulled low.
// Optional input glitch filter: define I2C_TGT_GLITCH_FILTER_EN (depth FILTER_LEN clk).
module i2c_target_reg #(
  parameter logic [6:0] ADDR       = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       rd_strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_filter_len_bad
    $error("FILTER_LEN must be in 2..15");
  end

  // bit 1 = scl, bit 0 = sda throughout the input path
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] line;
  logic [1:0] line_prev;

  // Two-flop synchronizer; idles high like the pulled-up bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {scl_i, sda_i};
      sync2 <= sync1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_filter
    logic [3:0] cnt;
    logic       val;
    // Accept a new level only after FILTER_LEN consecutive samples disagree with the held one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= 4'd0;
        val <= 1'b1;
      end else if (sync2[gi] == val) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        val <= sync2[gi];
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
    assign line[gi] = val;
  end
`else
  assign line = sync2;
`endif

  // Previous clean line levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) line_prev <= 2'b11;
    else      line_prev <= line;
  end

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  assign scl        = line[1];
  assign sda        = line[0];
  assign scl_rise   = scl & ~line_prev[1];
  assign scl_fall   = ~scl & line_prev[1];
  // Bus conditions win over a coincident scl edge
  assign start_cond = scl & line_prev[0] & ~sda;
  assign stop_cond  = scl & ~line_prev[0] & sda;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [6:0] tx_shift;     // remaining read bits after the MSB has been driven
  logic       rw;
  logic       master_nack;

  // Protocol FSM: sample on scl rise, change sda_oe only on scl fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      tx_shift    <= 7'h00;
      rw          <= 1'b0;
      master_nack <= 1'b0;
      sda_oe      <= 1'b0;
      rd_strobe   <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      addr_match  <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      rx_valid  <= 1'b0;
      if (start_cond) begin
        state      <= ADDR_S;
        bit_cnt    <= 4'd0;
        busy       <= 1'b1;
        addr_match <= 1'b0;
        sda_oe     <= 1'b0;
      end else if (stop_cond) begin
        state      <= IDLE;
        bit_cnt    <= 4'd0;
        busy       <= 1'b0;
        addr_match <= 1'b0;
        sda_oe     <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR_S, WRITE: begin
            shift   <= {shift[6:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
          end
          READ:     bit_cnt <= bit_cnt + 4'd1;
          READ_ACK: master_nack <= sda;
          default:  ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_S: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == ADDR) begin
                sda_oe     <= 1'b1;
                addr_match <= 1'b1;
                rw         <= shift[0];
                state      <= ADDR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (rw) begin
              tx_shift  <= tx_data[6:0];
              rd_strobe <= 1'b1;
              sda_oe    <= ~tx_data[7];
              state     <= READ;
            end else begin
              sda_oe <= 1'b0;
              state  <= WRITE;
            end
          end
          WRITE: begin
            if (bit_cnt == 4'd8) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              sda_oe   <= 1'b1;
              bit_cnt  <= 4'd0;
              state    <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            sda_oe <= 1'b0;
            state  <= WRITE;
          end
          READ: begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= READ_ACK;
            end else begin
              sda_oe   <= ~tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
          end
          READ_ACK: begin
            if (master_nack) begin
              sda_oe <= 1'b0;
              state  <= IGNORE;
            end else begin
              tx_shift  <= tx_data[6:0];
              rd_strobe <= 1'b1;
              sda_oe    <= ~tx_data[7];
              state     <= READ;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_reg.sv
// tb_i2c_target_reg: directed bus-master bench for i2c_target_reg (ADDR 7'h50, ~400 kHz bus).
module tb_i2c_target_reg;

  localparam int Q = 620;   // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       rd_strobe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       addr_match;

  int checks = 0;
  int failures = 0;
  int rxv_cnt, rds_cnt, low_cnt, am_cnt, both_cnt;
  logic cnt_clr = 1'b0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_reg #(.ADDR(7'h50), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .tx_data(tx_data), .rd_strobe(rd_strobe), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .addr_match(addr_match)
  );

  always @(posedge clk) begin
    if (cnt_clr) begin
      rxv_cnt <= 0; rds_cnt <= 0; low_cnt <= 0; am_cnt <= 0; both_cnt <= 0;
    end else begin
      rxv_cnt  <= rxv_cnt + int'(rx_valid);
      rds_cnt  <= rds_cnt + int'(rd_strobe);
      low_cnt  <= low_cnt + int'(sda_oe);
      am_cnt   <= am_cnt + int'(addr_match);
      both_cnt <= both_cnt + int'(rx_valid & rd_strobe);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  // One SCL clock; optional 2-clk low glitch in the high phase; samples bus and sda_oe mid-high
  task automatic clock_bit(input logic b, input logic glitch, output logic s_bus, output logic s_oe);
    sda_m = b; #Q;
    scl_m = 1'b1;
    if (glitch) begin
      #310; scl_m = 1'b0; #20; scl_m = 1'b1; #290;
    end else begin
      #Q;
    end
    s_bus = sda_i; s_oe = sda_oe;
    #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] data, input int gbit, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) clock_bit(data[i], (i == gbit), s, o);
    clock_bit(1'b1, 1'b0, ack, o);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] data, output logic oe9);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s, o);
      data[i] = s;
    end
    clock_bit(nack, 1'b0, s, oe9);
  endtask

  task automatic recover_bus();
    @(negedge clk); #Q; rst = 1'b1; #Q;
    scl_m = 1'b0; #Q;
    bus_stop();
  endtask

  initial begin
    logic ack, oe9, s, o;
    logic [7:0] rd;
    logic [7:0] glitch_exp;

    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rd_strobe", rd_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_match", addr_match, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Write A0, A5
    clear_counts();
    bus_start();
    check("wr_busy", busy, 1);
    write_byte(8'hA0, -1, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_addr_match", addr_match, 1);
    write_byte(8'hA5, -1, ack);
    check("wr_data_ack", ack, 0);
    bus_stop();
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rx_valid_cnt", rxv_cnt, 1);
    check("wr_busy_after_stop", busy, 0);
    check("wr_addr_match_after_stop", addr_match, 0);
    $display("txn write A0 A5 -> rx_data=%02h", rx_data);

    // Single-byte read of 3C with master NACK
    clear_counts();
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, -1, ack);
    check("rd_addr_ack", ack, 0);
    read_byte(1'b1, rd, oe9);
    bus_stop();
    check("rd_data", rd, 8'h3C);
    check("rd_strobe_cnt", rds_cnt, 1);
    check("rd_released_9th", oe9, 0);
    check("rd_no_rx_valid", rxv_cnt, 0);
    $display("txn read A1 -> %02h", rd);

    // Two-byte read: reload after master ACK picks up the new tx_data
    clear_counts();
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, -1, ack);
    tx_data = 8'h96;
    read_byte(1'b0, rd, oe9);
    check("rd2_byte0", rd, 8'h3C);
    read_byte(1'b1, rd, oe9);
    check("rd2_byte1", rd, 8'h96);
    bus_stop();
    check("rd2_strobe_cnt", rds_cnt, 2);
    $display("txn read2 A1 -> 3C,%02h", rd);

    // Wrong address
    clear_counts();
    bus_start();
    write_byte(8'hA4, -1, ack);
    check("wa_addr_nack", ack, 1);
    write_byte(8'h11, -1, ack);
    check("wa_data_nack", ack, 1);
    bus_stop();
    check("wa_sda_low_cnt", low_cnt, 0);
    check("wa_rx_valid_cnt", rxv_cnt, 0);
    check("wa_addr_match_cnt", am_cnt, 0);
    check("wa_rx_data_kept", rx_data, 8'hA5);
    $display("txn wrong-addr A4 11 -> ignored");

    // Repeated START: write 5A, then read it back
    clear_counts();
    bus_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h5A, -1, ack);
    bus_start();
    tx_data = 8'h5A;
    write_byte(8'hA1, -1, ack);
    check("rs_read_addr_ack", ack, 0);
    read_byte(1'b1, rd, oe9);
    bus_stop();
    check("rs_rx_data", rx_data, 8'h5A);
    check("rs_read_data", rd, 8'h5A);
    check("rs_rx_valid_cnt", rxv_cnt, 1);
    $display("txn repeated-start wr 5A rd %02h", rd);

    // Reset while the target holds the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, s, o);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    check("rack_oe_before", sda_oe, 1);
    #3 rst = 1'b0;
    #1;
    check("rack_oe_async", sda_oe, 0);
    check("rack_addr_match", addr_match, 0);
    check("rack_busy", busy, 0);
    recover_bus();
    $display("txn reset-in-ack released sda");

    // Reset during the 4th data bit of a write, then a full write
    rx_data_setup: begin
      bus_start();
      write_byte(8'hA0, -1, ack);
      write_byte(8'h66, -1, ack);
      check("rdat_pre_rx", rx_data, 8'h66);
      bus_start();
      write_byte(8'hA0, -1, ack);
      clock_bit(1'b1, 1'b0, s, o);
      clock_bit(1'b1, 1'b0, s, o);
      clock_bit(1'b0, 1'b0, s, o);
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q;
      #3 rst = 1'b0;
      #1;
      check("rdat_oe", sda_oe, 0);
      check("rdat_rx_data", rx_data, 8'h00);
      recover_bus();
    end
    clear_counts();
    bus_start();
    write_byte(8'hA0, -1, ack);
    check("post_rst_addr_ack", ack, 0);
    write_byte(8'h77, -1, ack);
    check("post_rst_data_ack", ack, 0);
    bus_stop();
    check("post_rst_rx_data", rx_data, 8'h77);
    check("post_rst_rx_valid_cnt", rxv_cnt, 1);
    $display("txn reset-in-data then write 77 -> rx_data=%02h", rx_data);

    // SCL glitch in the high phase of data bit 4 of A5
`ifdef I2C_TGT_GLITCH_FILTER_EN
    glitch_exp = 8'hA5;
`else
    glitch_exp = 8'hA2;
`endif
    clear_counts();
    bus_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'hA5, 4, ack);
    bus_stop();
    check("glitch_rx_data", rx_data, glitch_exp);
    check("glitch_rx_valid_cnt", rxv_cnt, 1);
    check("no_rxv_rds_overlap", both_cnt, 0);
    $display("txn glitch write A5 -> rx_data=%02h", rx_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
